// File: rtl/conv_window_scheduler.sv
// Walks every valid 3x3 output position in raster order, issuing one engine job per
// position and writing each result to the output SRAM under a ready/valid handshake.
module conv_window_scheduler #(
  parameter int unsigned IMG_W          = 8,
  parameter int unsigned IMG_H          = 8,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned OUT_ADDR_WIDTH = 6,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  output logic                      o_eng_start,
  output logic                      o_eng_load_kernel,
  output logic [ADDR_WIDTH-1:0]     o_eng_base_addr,
  input  logic                      i_eng_done,
  input  logic [DATA_WIDTH-1:0]     i_eng_result,
  output logic                      o_wr_valid,
  output logic [OUT_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0]     o_wr_data,
  input  logic                      i_wr_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error
);

  localparam int unsigned OutW = IMG_W - KERNEL_SIZE + 1;
  localparam int unsigned OutH = IMG_H - KERNEL_SIZE + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0]     LastCol  = ADDR_WIDTH'(OutW - 1);
  localparam logic [ADDR_WIDTH-1:0]     LastRow  = ADDR_WIDTH'(OutH - 1);
  localparam logic [ADDR_WIDTH-1:0]     AddrOne  = ADDR_WIDTH'(1);
  // Moving from the last column to column 0 of the next row skips KERNEL_SIZE pixels.
  localparam logic [ADDR_WIDTH-1:0]     WrapStep = ADDR_WIDTH'(KERNEL_SIZE);
  localparam logic [OUT_ADDR_WIDTH-1:0] OutOne   = OUT_ADDR_WIDTH'(1);
  localparam logic [TmoW-1:0]           TmoLast  = TmoW'(TIMEOUT - 1);
  localparam logic [TmoW-1:0]           TmoOne   = TmoW'(1);

  if (KERNEL_SIZE < 1) begin : gen_chk_kernel
    $error("KERNEL_SIZE must be at least 1");
  end
  if (IMG_W < KERNEL_SIZE || IMG_H < KERNEL_SIZE) begin : gen_chk_dims
    $error("IMG_W and IMG_H must be >= KERNEL_SIZE");
  end
  if (64'(IMG_W) * 64'(IMG_H) > (64'(1) << ADDR_WIDTH)) begin : gen_chk_addr
    $error("IMG_W*IMG_H does not fit in ADDR_WIDTH");
  end
  if (64'(OutW) * 64'(OutH) > (64'(1) << OUT_ADDR_WIDTH)) begin : gen_chk_out_addr
    $error("output map does not fit in OUT_ADDR_WIDTH");
  end
  if (TIMEOUT < 1) begin : gen_chk_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     row_q, row_d;
  logic [ADDR_WIDTH-1:0]     col_q, col_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [OUT_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [TmoW-1:0]           tmo_q, tmo_d;
  logic                      first_q, first_d;
  logic                      error_q, error_d;
  logic                      done_q, done_d;
  logic                      last_pos;

  assign last_pos = (row_q == LastRow) && (col_q == LastCol);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      base_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      tmo_q     <= '0;
      first_q   <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      tmo_q     <= tmo_d;
      first_q   <= first_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tmo_d     = tmo_q;
    first_d   = first_q;
    error_d   = error_q;
    done_d    = 1'b0;

    // Abort outranks start, done, handshake and timeout; the error flag is left alone.
    if (i_abort) begin
      state_d = StIdle;
      tmo_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d   = StIssue;
            row_d     = '0;
            col_d     = '0;
            base_d    = '0;
            wr_addr_d = '0;
            tmo_d     = '0;
            first_d   = 1'b1;
            error_d   = 1'b0;
          end
        end
        StIssue: begin
          first_d = 1'b0;
          state_d = StWait;
        end
        StWait: begin
          if (i_eng_done) begin
            wr_data_d = i_eng_result;
            tmo_d     = '0;
            state_d   = StWrite;
          end else if (tmo_q == TmoLast) begin
            error_d = 1'b1;
            tmo_d   = '0;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + TmoOne;
          end
        end
        StWrite: begin
          if (i_wr_ready) begin
            if (last_pos) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d   = StIssue;
              wr_addr_d = wr_addr_q + OutOne;
              if (col_q == LastCol) begin
                col_d  = '0;
                row_d  = row_q + AddrOne;
                base_d = base_q + WrapStep;
              end else begin
                col_d  = col_q + AddrOne;
                base_d = base_q + AddrOne;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Strobes are masked by abort so nothing is issued or written in the abort cycle.
  assign o_eng_start       = (state_q == StIssue) && !i_abort;
  assign o_eng_load_kernel = o_eng_start && first_q;
  assign o_eng_base_addr   = base_q;
  assign o_wr_valid        = (state_q == StWrite) && !i_abort;
  assign o_wr_addr         = wr_addr_q;
  assign o_wr_data         = wr_data_q;
  assign o_busy            = (state_q != StIdle);
  assign o_done            = done_q;
  assign o_error           = error_q;

endmodule
